// File: rtl/batrider_coin_cond.sv
// Coin-input conditioner for batrider_game.coin_input: synchronise, debounce,
// queue and re-time four active-low coin switches into fixed-width pulses.
module batrider_coin_cond #(
   parameter int CLK_HZ         = 48000000,
   parameter int TICK_HZ        = 1000,
   parameter int DEBOUNCE_TICKS = 5,
   parameter int PULSE_TICKS    = 50,
   parameter int GAP_TICKS      = 50,
   parameter int QDEPTH         = 3
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_coin_in,
   input  logic [3:0] i_lockout,
   output logic [3:0] o_coin_out,
   output logic [3:0] o_coin_mtr,
   output logic [3:0] o_coin_rej,
   output logic       o_busy
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW   = $clog2(DEBOUNCE_TICKS) + 1;
   localparam int TMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int QW   = $clog2(QDEPTH + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DC_LAST    = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
   localparam logic [QW-1:0] Q_FULL     = QW'(QDEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [PW-1:0] r_presc;
   logic          w_tick;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    w_busy;

   assign w_tick = (r_presc == PRESC_LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Released (high) is the safe power-up value for the synchroniser.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= i_coin_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_ch
      logic          r_db;
      logic [DW-1:0] r_dc;
      logic          r_press;
      logic [QW-1:0] r_q;
      logic [1:0]    r_state;
      logic [TW-1:0] r_tc;
      logic          r_out;
      logic          r_mtr;
      logic          r_rej;
      logic          w_deq;
      logic          w_accept;

      assign w_deq    = (r_state == ST_IDLE) && (r_q != '0);
      // A dequeue in the same cycle frees a slot, so a full queue still accepts.
      assign w_accept = r_press && !i_lockout[g] && (w_deq || (r_q != Q_FULL));

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            r_db    <= 1'b1;
            r_dc    <= '0;
            r_press <= 1'b0;
         end else begin
            r_press <= 1'b0;
            if (r_sync2[g] == r_db) begin
               r_dc <= '0;
            end else if (w_tick) begin
               if (r_dc == DC_LAST) begin
                  r_db    <= r_sync2[g];
                  r_dc    <= '0;
                  r_press <= r_db;
               end else begin
                  r_dc <= r_dc + 1'b1;
               end
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            r_q   <= '0;
            r_rej <= 1'b0;
         end else begin
            r_rej <= r_press && !w_accept;
            if (w_accept && !w_deq) begin
               r_q <= r_q + 1'b1;
            end else if (w_deq && !w_accept) begin
               r_q <= r_q - 1'b1;
            end
         end
      end

      // Pulse/gap sequencer; TC counts shared timebase ticks.
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            r_state <= ST_IDLE;
            r_tc    <= '0;
            r_out   <= 1'b1;
            r_mtr   <= 1'b0;
         end else begin
            r_mtr <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_deq) begin
                     r_state <= ST_PULSE;
                     r_tc    <= '0;
                     r_out   <= 1'b0;
                     r_mtr   <= 1'b1;
                  end
               end
               ST_PULSE: begin
                  if (w_tick) begin
                     if (r_tc == PULSE_LAST) begin
                        r_state <= ST_GAP;
                        r_tc    <= '0;
                        r_out   <= 1'b1;
                     end else begin
                        r_tc <= r_tc + 1'b1;
                     end
                  end
               end
               ST_GAP: begin
                  if (w_tick) begin
                     if (r_tc == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_tc    <= '0;
                     end else begin
                        r_tc <= r_tc + 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_tc    <= '0;
                  r_out   <= 1'b1;
               end
            endcase
         end
      end

      assign o_coin_out[g] = r_out;
      assign o_coin_mtr[g] = r_mtr;
      assign o_coin_rej[g] = r_rej;
      assign w_busy[g]     = (r_state != ST_IDLE) || (r_q != '0);
   end

   assign o_busy = |w_busy;

endmodule

// File: tb/tb_batrider_coin_cond.sv
// Scoreboard bench for batrider_coin_cond with a 10-clock tick (CLK_HZ=10000).
module tb_batrider_coin_cond;

   localparam int CLK_HZ  = 10000;
   localparam int TICK_HZ = 1000;
   localparam int W_MIN   = 490;
   localparam int W_MAX   = 500;
   localparam int GAP_MIN = 500;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] coin_in;
   logic [3:0] lockout;
   logic [3:0] coin_out;
   logic [3:0] coin_mtr;
   logic [3:0] coin_rej;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_q[$];
   int rd_idx = 0;

   int       cyc = 0;
   logic [3:0] prev_out = 4'hF;
   logic     prev_busy = 1'b0;
   int       busy_fall_cyc = 0;
   int       fall_cyc[4] = '{default: 0};
   int       rise_cyc[4] = '{default: -100000};
   int       gap_pend[4] = '{default: 0};
   int       mtr_cnt[4]  = '{default: 0};
   int       rej_cnt[4]  = '{default: 0};
   int       fall_cnt[4] = '{default: 0};
   int       mtr_cyc[4]  = '{default: 0};
   int       obs_n = 0;
   int       obs_ch[64];
   int       obs_w[64];
   int       obs_gap[64];

   batrider_coin_cond #(
      .CLK_HZ (CLK_HZ),
      .TICK_HZ(TICK_HZ)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_coin_in (coin_in),
      .i_lockout (lockout),
      .o_coin_out(coin_out),
      .o_coin_mtr(coin_mtr),
      .o_coin_rej(coin_rej),
      .o_busy    (busy)
   );

   always #5 clk = ~clk;

   // Output monitor: records every completed pulse with its width and preceding gap.
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (coin_mtr[c] === 1'b1) begin
            mtr_cnt[c]++;
            mtr_cyc[c] = cyc;
         end
         if (coin_rej[c] === 1'b1) rej_cnt[c]++;
         if (prev_out[c] === 1'b1 && coin_out[c] === 1'b0) begin
            fall_cyc[c] = cyc;
            gap_pend[c] = cyc - rise_cyc[c];
            fall_cnt[c]++;
         end
         if (prev_out[c] === 1'b0 && coin_out[c] === 1'b1) begin
            if (obs_n < 64) begin
               obs_ch[obs_n]  = c;
               obs_w[obs_n]   = cyc - fall_cyc[c];
               obs_gap[obs_n] = gap_pend[c];
               obs_n++;
            end
            rise_cyc[c] = cyc;
         end
      end
      if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
      prev_out  = coin_out;
      prev_busy = busy;
      cyc++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int ch);
      coin_in[ch] = 1'b0;
      repeat (70) step();
      coin_in[ch] = 1'b1;
      repeat (70) step();
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 1200 && busy !== 1'b0; k++) step();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy timeout: busy=%b required 0", name, busy);
      end
      repeat (2) step();
   endtask

   task automatic check_pulses(input string name, input int n, input int limit);
      int k;
      int e;
      for (k = 0; k < limit && obs_n < rd_idx + n; k++) step();
      n_tests++;
      if (obs_n < rd_idx + n) begin
         n_fail++;
         $display("FAIL %s pulse timeout: observed %0d pulses, required %0d", name, obs_n - rd_idx, n);
         exp_q.delete();
         rd_idx = obs_n;
         return;
      end
      for (int i = 0; i < n; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         n_tests++;
         if (obs_ch[rd_idx] !== e) begin
            n_fail++;
            $display("FAIL %s channel #%0d: got ch%0d, expected ch%0d", name, i, obs_ch[rd_idx], e);
         end
         n_tests++;
         if (obs_w[rd_idx] < W_MIN || obs_w[rd_idx] > W_MAX) begin
            n_fail++;
            $display("FAIL %s width #%0d: got %0d clk, expected %0d..%0d", name, i, obs_w[rd_idx], W_MIN, W_MAX);
         end
         n_tests++;
         if (obs_gap[rd_idx] < GAP_MIN) begin
            n_fail++;
            $display("FAIL %s gap #%0d: got %0d clk, expected >= %0d", name, i, obs_gap[rd_idx], GAP_MIN);
         end
         rd_idx++;
      end
   endtask

   task automatic test_reset();
      int bad;
      reset   = 1'b1;
      coin_in = 4'h0;
      lockout = 4'h0;
      repeat (3) step();
      n_tests++;
      if (coin_out !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_coin_out: got %h, expected F", coin_out);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b, expected 0", busy);
      end
      n_tests++;
      if (coin_mtr !== 4'h0 || coin_rej !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_strobes: mtr=%h rej=%h, expected 0 0", coin_mtr, coin_rej);
      end
      // Switches held low through reset become one press per channel after debounce.
      for (int c = 0; c < 4; c++) exp_q.push_back(c);
      reset = 1'b0;
      bad   = 0;
      repeat (30) begin
         step();
         if (coin_out !== 4'hF) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_hold_released: %0d cycles not F, expected 0", bad);
      end
      repeat (70) step();
      coin_in = 4'hF;
      check_pulses("reset_release_all", 4, 1500);
      for (int c = 1; c < 4; c++) begin
         n_tests++;
         if (mtr_cyc[c] !== mtr_cyc[0]) begin
            n_fail++;
            $display("FAIL simultaneous_mtr ch%0d: cycle %0d, expected %0d", c, mtr_cyc[c], mtr_cyc[0]);
         end
      end
      wait_idle("reset_release_all");
   endtask

   task automatic test_single_coin();
      int m0;
      m0 = mtr_cnt[0];
      exp_q.push_back(0);
      coin_in[0] = 1'b0;
      repeat (200) step();
      coin_in[0] = 1'b1;
      n_tests++;
      if (mtr_cnt[0] - m0 !== 1) begin
         n_fail++;
         $display("FAIL single_mtr: got %0d strobes, expected 1", mtr_cnt[0] - m0);
      end
      check_pulses("single_coin", 1, 1000);
      wait_idle("single_coin");
      n_tests++;
      if (busy_fall_cyc - rise_cyc[0] < GAP_MIN) begin
         n_fail++;
         $display("FAIL single_busy_gap: busy fell %0d clk after rise, expected >= %0d",
                  busy_fall_cyc - rise_cyc[0], GAP_MIN);
      end
      n_tests++;
      if (mtr_cnt[0] - m0 !== 1) begin
         n_fail++;
         $display("FAIL single_mtr_total: got %0d strobes, expected 1", mtr_cnt[0] - m0);
      end
   endtask

   task automatic test_bounce();
      int m1, r1, f1, o1;
      m1 = mtr_cnt[1];
      r1 = rej_cnt[1];
      f1 = fall_cnt[1];
      o1 = obs_n;
      for (int i = 0; i < 20; i++) begin
         coin_in[1] = ~coin_in[1];
         repeat (15) step();
      end
      coin_in[1] = 1'b1;
      repeat (200) step();
      n_tests++;
      if (fall_cnt[1] - f1 !== 0 || coin_out[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_out: falls=%0d out=%b, expected 0 and 1", fall_cnt[1] - f1, coin_out[1]);
      end
      n_tests++;
      if (mtr_cnt[1] - m1 !== 0 || rej_cnt[1] - r1 !== 0) begin
         n_fail++;
         $display("FAIL bounce_strobes: mtr=%0d rej=%0d, expected 0 0", mtr_cnt[1] - m1, rej_cnt[1] - r1);
      end
      n_tests++;
      if (obs_n !== o1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_idle: pulses=%0d busy=%b, expected 0 0", obs_n - o1, busy);
      end
   endtask

   task automatic test_queue();
      int r2, m2;
      r2 = rej_cnt[2];
      m2 = mtr_cnt[2];
      for (int i = 0; i < 4; i++) exp_q.push_back(2);
      for (int i = 0; i < 5; i++) press(2);
      n_tests++;
      if (rej_cnt[2] - r2 !== 1) begin
         n_fail++;
         $display("FAIL queue_full_rej: got %0d rejects, expected 1", rej_cnt[2] - r2);
      end
      check_pulses("queue", 4, 6000);
      wait_idle("queue");
      n_tests++;
      if (mtr_cnt[2] - m2 !== 4) begin
         n_fail++;
         $display("FAIL queue_mtr: got %0d strobes, expected 4", mtr_cnt[2] - m2);
      end
   endtask

   task automatic test_lockout();
      int r3, m3, f3;
      r3 = rej_cnt[3];
      m3 = mtr_cnt[3];
      f3 = fall_cnt[3];
      lockout[3] = 1'b1;
      press(3);
      repeat (100) step();
      n_tests++;
      if (rej_cnt[3] - r3 !== 1) begin
         n_fail++;
         $display("FAIL lockout_rej: got %0d rejects, expected 1", rej_cnt[3] - r3);
      end
      n_tests++;
      if (mtr_cnt[3] - m3 !== 0 || fall_cnt[3] - f3 !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL lockout_no_pulse: mtr=%0d falls=%0d busy=%b, expected 0 0 0",
                  mtr_cnt[3] - m3, fall_cnt[3] - f3, busy);
      end
      lockout[3] = 1'b0;
      exp_q.push_back(3);
      press(3);
      n_tests++;
      if (coin_out[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL lockout_pulse_active: out=%b, expected 0", coin_out[3]);
      end
      lockout[3] = 1'b1;
      check_pulses("lockout_mid_pulse", 1, 1000);
      wait_idle("lockout_mid_pulse");
      lockout[3] = 1'b0;
      n_tests++;
      if (rej_cnt[3] - r3 !== 1) begin
         n_fail++;
         $display("FAIL lockout_mid_rej: got %0d rejects, expected 1", rej_cnt[3] - r3);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int f0, m0;
      for (int i = 0; i < 3; i++) press(0);
      n_tests++;
      if (coin_out[0] !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pulse_pre: out=%b busy=%b, expected 0 1", coin_out[0], busy);
      end
      reset = 1'b1;
      step();
      n_tests++;
      if (coin_out[0] !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pulse_reset: out=%b busy=%b, expected 1 0", coin_out[0], busy);
      end
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();
      rd_idx = obs_n;
      f0 = fall_cnt[0];
      m0 = mtr_cnt[0];
      repeat (1500) step();
      n_tests++;
      if (fall_cnt[0] - f0 !== 0 || mtr_cnt[0] - m0 !== 0) begin
         n_fail++;
         $display("FAIL mid_pulse_queue_dropped: falls=%0d mtr=%0d, expected 0 0",
                  fall_cnt[0] - f0, mtr_cnt[0] - m0);
      end
      n_tests++;
      if (busy !== 1'b0 || coin_out !== 4'hF) begin
         n_fail++;
         $display("FAIL mid_pulse_idle: busy=%b out=%h, expected 0 F", busy, coin_out);
      end
   endtask

   initial begin
      reset   = 1'b1;
      coin_in = 4'h0;
      lockout = 4'h0;
      test_reset();
      test_single_coin();
      test_bounce();
      test_queue();
      test_lockout();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
